// File: rtl/header_run_detect_pkg.sv
// Shared types and constants for the SFP header-run detector and its word matcher.
package header_run_detect_pkg;

  localparam int unsigned        DATA_W_DEF      = 16;
  localparam int unsigned        HDR_COUNT_DEF   = 6;
  localparam int unsigned        CNT_W_DEF       = 4;
  localparam logic [15:0]        HEADER_WORD_DEF = 16'hBC50;
  localparam logic [1:0]         KCHAR_LOW       = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_LOCKED = 2'd2
  } hdr_state_e;

endpackage

// File: rtl/header_run_detect_word_match.sv
// Combinational header-word compare; HDR_KCHAR_CHECK_EN also requires a K-char on the low byte.
module header_word_match
  import header_run_detect_pkg::*;
#(
  parameter int unsigned          DATA_W      = DATA_W_DEF,
  parameter logic [DATA_W-1:0]    HEADER_WORD = DATA_W'(HEADER_WORD_DEF)
) (
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic [1:0]        rx_charisk,
  output logic              match_c
);

`ifdef HDR_KCHAR_CHECK_EN
  assign match_c = rx_valid && (rx_data == HEADER_WORD) && (rx_charisk == KCHAR_LOW);
`else
  logic unused_charisk_c;
  assign unused_charisk_c = ^rx_charisk;
  assign match_c = rx_valid && (rx_data == HEADER_WORD);
`endif

endmodule

// File: rtl/header_run_detect.sv
// Locks onto a run of HDR_COUNT consecutive header words and flags it, with a delayed copy
// for the downstream falling-edge stage. Optional macro: HDR_KCHAR_CHECK_EN.
module header_run_detect
  import header_run_detect_pkg::*;
#(
  parameter int unsigned          DATA_W      = DATA_W_DEF,
  parameter logic [DATA_W-1:0]    HEADER_WORD = DATA_W'(HEADER_WORD_DEF),
  parameter int unsigned          HDR_COUNT   = HDR_COUNT_DEF,
  parameter int unsigned          CNT_W       = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic [1:0]        rx_charisk,
  output logic              hdr_sig,
  output logic              hdr_pre_sig,
  output logic              hdr_err,
  output logic [CNT_W-1:0]  run_cnt,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOCK = CNT_W'(HDR_COUNT);

  logic              match_c;
  hdr_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sig_q, sig_d;
  logic              pre_q, pre_d;
  logic              err_q, err_d;
  logic              ov_q, ov_d;
  logic [DATA_W-1:0] od_q, od_d;

  header_word_match #(
    .DATA_W      (DATA_W),
    .HEADER_WORD (HEADER_WORD)
  ) u_match (
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_charisk (rx_charisk),
    .match_c    (match_c)
  );

  // Next-state: only valid words advance the run; idle cycles hold everything but the pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    err_d   = 1'b0;
    pre_d   = sig_q;
    ov_d    = rx_valid;
    od_d    = rx_valid ? rx_data : od_q;
    if (rx_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (match_c) begin
            cnt_d   = CNT_ONE;
            state_d = ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (match_c) begin
            cnt_d = cnt_q + CNT_ONE;
            if ((cnt_q + CNT_ONE) == CNT_LOCK) begin
              state_d = ST_LOCKED;
              sig_d   = 1'b1;
            end
          end else begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
        ST_LOCKED: begin
          if (match_c) begin
            cnt_d = CNT_LOCK;
          end else begin
            sig_d   = 1'b0;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          sig_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sig_q   <= 1'b0;
      pre_q   <= 1'b0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      pre_q   <= pre_d;
      err_q   <= err_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
    end
  end

  assign hdr_sig     = sig_q;
  assign hdr_pre_sig = pre_q;
  assign hdr_err     = err_q;
  assign run_cnt     = cnt_q;
  assign out_valid   = ov_q;
  assign out_data    = od_q;

endmodule

// File: tb/tb_header_run_detect.sv
// Directed plus randomized bench for header_run_detect against a run-length reference model.
module tb_header_run_detect;

  localparam int unsigned HC = 6;
  localparam logic [15:0] HW = 16'hBC50;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic [1:0]  rx_charisk;
  logic        hdr_sig, hdr_pre_sig, hdr_err, out_valid;
  logic [3:0]  run_cnt;
  logic [15:0] out_data;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: length of the current header run plus the visible output values.
  int          m_run;
  logic        m_sig, m_pre, m_err, m_ov;
  logic [15:0] m_od;

  header_run_detect dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_charisk  (rx_charisk),
    .hdr_sig     (hdr_sig),
    .hdr_pre_sig (hdr_pre_sig),
    .hdr_err     (hdr_err),
    .run_cnt     (run_cnt),
    .out_valid   (out_valid),
    .out_data    (out_data)
  );

  always #5 clk = ~clk;

  function automatic logic model_match(input logic v, input logic [15:0] d, input logic [1:0] k);
`ifdef HDR_KCHAR_CHECK_EN
    return v && (d == HW) && (k == 2'b01);
`else
    return v && (d == HW) && (k == k);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_sig = 1'b0; m_pre = 1'b0; m_err = 1'b0; m_ov = 1'b0; m_od = '0;
  endtask

  task automatic model_clock(input logic v, input logic [15:0] d, input logic [1:0] k);
    m_pre = m_sig;
    m_err = 1'b0;
    m_ov  = v;
    if (v) begin
      m_od = d;
      if (model_match(v, d, k)) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_err = (m_run > 0) && (m_run < int'(HC));
        m_run = 0;
      end
    end
    m_sig = (m_run >= int'(HC));
  endtask

  task automatic check_all();
    int exp_cnt;
    exp_cnt = (m_run > int'(HC)) ? int'(HC) : m_run;
    chk("hdr_sig",     32'(hdr_sig),     32'(m_sig));
    chk("hdr_pre_sig", 32'(hdr_pre_sig), 32'(m_pre));
    chk("hdr_err",     32'(hdr_err),     32'(m_err));
    chk("run_cnt",     32'(run_cnt),     32'(exp_cnt));
    chk("out_valid",   32'(out_valid),   32'(m_ov));
    chk("out_data",    32'(out_data),    32'(m_od));
  endtask

  task automatic step_r(input logic r, input logic v, input logic [15:0] d, input logic [1:0] k);
    @(negedge clk);
    rst_n = r; rx_valid = v; rx_data = d; rx_charisk = k;
    @(posedge clk);
    if (rst_n) model_clock(v, d, k);
    else       model_reset();
    #1;
    check_all();
  endtask

  task automatic step(input logic v, input logic [15:0] d, input logic [1:0] k);
    step_r(1'b1, v, d, k);
  endtask

  initial begin
    rst_n = 1'b0; rx_valid = 1'b1; rx_data = HW; rx_charisk = 2'b01;
    model_reset();
    #1;
    check_all();
    for (int i = 0; i < 3; i++) step_r(1'b0, 1'b1, HW, 2'b01);

    // First lock: hdr_sig after the sixth sampled header, hdr_pre_sig one clock later.
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, HW, 2'b01);
      if (i == 5) chk("no_early_lock", 32'(hdr_sig), 32'd0);
    end
    chk("lock_rise", 32'(hdr_sig), 32'd1);
    chk("pre_lag", 32'(hdr_pre_sig), 32'd0);
    step(1'b1, 16'h1234, 2'b00);
    chk("fall_sig", 32'(hdr_sig), 32'd0);
    chk("fall_pre", 32'(hdr_pre_sig), 32'd1);
    chk("fall_data", 32'(out_data), 32'h1234);
    chk("fall_no_err", 32'(hdr_err), 32'd0);

    // Broken run before lock.
    for (int i = 0; i < 4; i++) step(1'b1, HW, 2'b01);
    step(1'b1, 16'h0000, 2'b00);
    chk("break_err", 32'(hdr_err), 32'd1);
    chk("break_cnt", 32'(run_cnt), 32'd0);
    step(1'b0, 16'h5555, 2'b00);
    chk("err_one_cycle", 32'(hdr_err), 32'd0);

    // Run spanning an idle gap.
    for (int i = 0; i < 3; i++) step(1'b1, HW, 2'b01);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 16'hDEAD, 2'b00);
      chk("gap_out_valid", 32'(out_valid), 32'd0);
    end
    for (int i = 0; i < 3; i++) step(1'b1, HW, 2'b01);
    chk("gap_lock_cnt", 32'(run_cnt), 32'd6);
    chk("gap_lock_sig", 32'(hdr_sig), 32'd1);

    // Saturation then asynchronous mid-run reset.
    for (int i = 0; i < 10; i++) step(1'b1, HW, 2'b01);
    chk("sat_cnt", 32'(run_cnt), 32'd6);
    chk("sat_sig", 32'(hdr_sig), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_sig", 32'(hdr_sig), 32'd0);
    chk("async_pre", 32'(hdr_pre_sig), 32'd0);
    chk("async_cnt", 32'(run_cnt), 32'd0);
    model_reset();
    step(1'b0, 16'h0000, 2'b00);

    // Header value with wrong K-char flags, then with the right ones.
    for (int i = 0; i < 6; i++) step(1'b1, HW, 2'b00);
`ifdef HDR_KCHAR_CHECK_EN
    chk("kchar_bad_nolock", 32'(hdr_sig), 32'd0);
`else
    chk("kchar_ignored_lock", 32'(hdr_sig), 32'd1);
`endif
    step(1'b1, 16'h0BAD, 2'b00);
    for (int i = 0; i < 6; i++) step(1'b1, HW, 2'b01);
    chk("kchar_good_lock", 32'(hdr_sig), 32'd1);

    // Randomized traffic, header-biased so runs of six occur often.
    for (int i = 0; i < 400; i++) begin
      logic        v;
      logic [15:0] d;
      logic [1:0]  k;
      v = ($urandom_range(0, 7) != 0);
      d = ($urandom_range(0, 4) != 0) ? HW : 16'($urandom);
      k = ($urandom_range(0, 5) != 0) ? 2'b01 : 2'($urandom);
      step(v, d, k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
